// File: rtl/udp_cmd_parser.sv
// udp_cmd_parser: frames a UDP payload byte stream into 32-bit command words.
// Frame layout: HDR0 HDR1 C3 C2 C1 C0 CHK, where CHK = (C3+C2+C1+C0) mod 256.
// Accepted commands are held in command_byte and announced with a one-cycle
// cmd_valid strobe. Malformed, aborted and timed-out frames bump err_cnt.
// Good frames that arrive while downstream is busy bump drop_cnt.
module udp_cmd_parser #(
  parameter logic [7:0] HDR0        = 8'h55,
  parameter logic [7:0] HDR1        = 8'hAA,
  parameter int         TIMEOUT_CYC = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic        cmd_ready,
  output logic [31:0] command_byte,
  output logic        cmd_valid,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int            TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_HDR0, S_HDR1, S_CMD, S_CHK} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [31:0]   shreg_reg, shreg_next;
  logic [7:0]    chk_reg, chk_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          err_ev;
  logic          good_ev;

  // Frame state, shift register, checksum and idle-timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_HDR0;
      idx_reg   <= '0;
      shreg_reg <= '0;
      chk_reg   <= '0;
      tcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
      chk_reg   <= chk_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  // Next-state logic: byte handling first, then timeout, then packet-end abort.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    chk_next   = chk_reg;
    tcnt_next  = tcnt_reg;
    err_ev     = 1'b0;
    good_ev    = 1'b0;

    if (rec_en) begin
      case (state_reg)
        S_HDR0: begin
          // Anything but the sync byte is silently skipped while hunting.
          if (rec_data == HDR0) state_next = S_HDR1;
        end
        S_HDR1: begin
          if (rec_data == HDR1) begin
            state_next = S_CMD;
            idx_next   = '0;
            chk_next   = '0;
          end else if (rec_data != HDR0) begin
            // A repeated HDR0 keeps us waiting for HDR1; anything else is bad.
            state_next = S_HDR0;
            err_ev     = 1'b1;
          end
        end
        S_CMD: begin
          shreg_next = {shreg_reg[23:0], rec_data};
          chk_next   = chk_reg + rec_data;
          idx_next   = idx_reg + 2'd1;
          if (idx_reg == 2'd3) state_next = S_CHK;
        end
        S_CHK: begin
          if (rec_data == chk_reg) good_ev = 1'b1;
          else                     err_ev  = 1'b1;
          state_next = S_HDR0;
        end
        default: state_next = S_HDR0;
      endcase
    end else if (state_reg != S_HDR0 && tcnt_reg == T_LAST) begin
      // Sender went quiet mid-frame; a byte on this cycle would have won.
      err_ev     = 1'b1;
      state_next = S_HDR0;
    end

    // Packet ended with a frame still open: the frame can never complete.
    if (rec_pkt_done && state_next != S_HDR0) begin
      err_ev     = 1'b1;
      state_next = S_HDR0;
    end

    // Idle counter only runs inside a frame and restarts on every byte.
    if (state_next == S_HDR0 || rec_en) tcnt_next = '0;
    else                                tcnt_next = tcnt_reg + TW'(1);
  end

  // Registered outputs: command latch, strobe and saturating debug counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command_byte <= '0;
      cmd_valid    <= 1'b0;
      err_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      cmd_valid <= good_ev && cmd_ready;
      if (good_ev && cmd_ready) command_byte <= shreg_reg;
      if (good_ev && !cmd_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Testbench for udp_cmd_parser: directed vector table, hand-written reset
// sequence, then randomized frames checked against a frame-level model.
module tb_udp_cmd_parser;

  localparam int TOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic        cmd_ready;
  logic [31:0] command_byte;
  logic        cmd_valid;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  udp_cmd_parser #(
    .HDR0(8'h55),
    .HDR1(8'hAA),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rec_en(rec_en),
    .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done),
    .cmd_ready(cmd_ready),
    .command_byte(command_byte),
    .cmd_valid(cmd_valid),
    .err_cnt(err_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit use_model = 0;

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic        done;
    logic        ready;
    logic        ev;
    logic [31:0] ecmd;
    logic [7:0]  eerr;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tbl[$];

  // Frame-level reference model: progress through the 7-byte frame as a count,
  // command bytes collected in a queue, word and checksum computed at the end.
  int          m_pos;
  int          m_idle;
  logic [7:0]  m_q[$];
  logic [31:0] m_cmd;
  logic        m_valid;
  int          m_err;
  int          m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_q.delete();
    m_cmd = '0; m_valid = 1'b0; m_err = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic en, input logic [7:0] d, input logic done, input logic ready);
    bit          e;
    bit          nv;
    logic [7:0]  sum;
    logic [31:0] w;
    e = 0; nv = 0;
    if (en) begin
      m_idle = 0;
      if (m_pos == 0) begin
        if (d == 8'h55) m_pos = 1;
      end else if (m_pos == 1) begin
        if (d == 8'hAA) begin m_pos = 2; m_q.delete(); end
        else if (d != 8'h55) begin m_pos = 0; e = 1; end
      end else if (m_pos < 6) begin
        m_q.push_back(d);
        m_pos++;
      end else begin
        sum = 8'd0; w = 32'd0;
        foreach (m_q[i]) begin
          sum = sum + m_q[i];
          w = (w << 8) | 32'(m_q[i]);
        end
        if (d == sum) begin
          if (ready) begin m_cmd = w; nv = 1; end
          else if (m_drop < 255) m_drop++;
        end else e = 1;
        m_pos = 0;
      end
    end else if (m_pos != 0) begin
      m_idle++;
      if (m_idle == TOUT) begin e = 1; m_pos = 0; end
    end
    if (done && m_pos != 0) begin e = 1; m_pos = 0; end
    if (m_pos == 0) m_idle = 0;
    if (e && m_err < 255) m_err++;
    m_valid = nv;
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic en, input logic [7:0] d, input logic done, input logic ready);
    rec_en = en; rec_data = d; rec_pkt_done = done; cmd_ready = ready;
    @(posedge clk);
    model_step(en, d, done, ready);
    #1;
    if (use_model) begin
      check("model_valid", 32'(cmd_valid), 32'(m_valid));
      check("model_cmd",   command_byte,   m_cmd);
      check("model_err",   32'(err_cnt),   32'(m_err));
      check("model_drop",  32'(drop_cnt),  32'(m_drop));
    end
  endtask

  task automatic add(input logic en, input logic [7:0] d, input logic done, input logic rdy,
                     input logic ev, input logic [31:0] ec, input logic [7:0] ee, input logic [7:0] ed);
    vec_t v;
    v.en = en; v.data = d; v.done = done; v.ready = rdy;
    v.ev = ev; v.ecmd = ec; v.eerr = ee; v.edrop = ed;
    tbl.push_back(v);
  endtask

  // Byte with no strobe expected.
  task automatic addb(input logic [7:0] d, input logic [31:0] ec, input logic [7:0] ee, input logic [7:0] ed);
    add(1'b1, d, 1'b0, 1'b1, 1'b0, ec, ee, ed);
  endtask

  task automatic addi(input int n, input logic [31:0] ec, input logic [7:0] ee, input logic [7:0] ed);
    for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ec, ee, ed);
  endtask

  initial begin
    logic [7:0] fr[7];
    logic [7:0] csum;
    int         kind;
    int         gap;

    rst_n = 1'b0; rec_en = 1'b0; rec_data = 8'h00; rec_pkt_done = 1'b0; cmd_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_cmd",   command_byte,   32'h0);
    check("reset_valid", 32'(cmd_valid), 32'h0);
    check("reset_err",   32'(err_cnt),   32'h0);
    check("reset_drop",  32'(drop_cnt),  32'h0);
    rst_n = 1'b1;

    // Good frame, latency one clock after CHK.
    addb(8'h55, 0, 0, 0); addb(8'hAA, 0, 0, 0); addb(8'h00, 0, 0, 0);
    addb(8'h00, 0, 0, 0); addb(8'h01, 0, 0, 0); addb(8'h52, 0, 0, 0);
    add(1, 8'h53, 0, 1, 1, 32'h152, 0, 0);
    addi(1, 32'h152, 0, 0);
    // Bad checksum, then good frame.
    addb(8'h55, 32'h152, 0, 0); addb(8'hAA, 32'h152, 0, 0); addb(8'h00, 32'h152, 0, 0);
    addb(8'h00, 32'h152, 0, 0); addb(8'h00, 32'h152, 0, 0); addb(8'h41, 32'h152, 0, 0);
    addb(8'h40, 32'h152, 1, 0);
    addb(8'h55, 32'h152, 1, 0); addb(8'hAA, 32'h152, 1, 0); addb(8'h00, 32'h152, 1, 0);
    addb(8'h00, 32'h152, 1, 0); addb(8'h00, 32'h152, 1, 0); addb(8'h41, 32'h152, 1, 0);
    add(1, 8'h41, 0, 1, 1, 32'h41, 1, 0);
    // Resync through garbage and a repeated sync byte, then bad HDR1.
    addb(8'h12, 32'h41, 1, 0); addb(8'h55, 32'h41, 1, 0); addb(8'h55, 32'h41, 1, 0);
    addb(8'hAA, 32'h41, 1, 0); addb(8'h00, 32'h41, 1, 0); addb(8'h00, 32'h41, 1, 0);
    addb(8'h00, 32'h41, 1, 0); addb(8'h42, 32'h41, 1, 0);
    add(1, 8'h42, 0, 1, 1, 32'h42, 1, 0);
    addb(8'h55, 32'h42, 1, 0); addb(8'h13, 32'h42, 2, 0);
    // Packet end mid-frame.
    addb(8'h55, 32'h42, 2, 0); addb(8'hAA, 32'h42, 2, 0); addb(8'h00, 32'h42, 2, 0);
    add(1, 8'h00, 1, 1, 0, 32'h42, 3, 0);
    addb(8'h00, 32'h42, 3, 0);
    // Timeout: fires on the 16th idle cycle inside the frame.
    addb(8'h55, 32'h42, 3, 0); addb(8'hAA, 32'h42, 3, 0); addb(8'h00, 32'h42, 3, 0);
    addi(TOUT - 1, 32'h42, 3, 0);
    addi(1, 32'h42, 4, 0);
    addi(4, 32'h42, 4, 0);
    addb(8'h55, 32'h42, 4, 0); addb(8'hAA, 32'h42, 4, 0); addb(8'h00, 32'h42, 4, 0);
    addb(8'h00, 32'h42, 4, 0); addb(8'h00, 32'h42, 4, 0); addb(8'h09, 32'h42, 4, 0);
    add(1, 8'h09, 0, 1, 1, 32'h9, 4, 0);
    // Back-pressure: ready low only on the CHK byte.
    addb(8'h55, 32'h9, 4, 0); addb(8'hAA, 32'h9, 4, 0); addb(8'h00, 32'h9, 4, 0);
    addb(8'h00, 32'h9, 4, 0); addb(8'h00, 32'h9, 4, 0); addb(8'h07, 32'h9, 4, 0);
    add(1, 8'h07, 0, 0, 0, 32'h9, 4, 1);
    // Two frames back-to-back: strobes 7 cycles apart.
    addb(8'h55, 32'h9, 4, 1); addb(8'hAA, 32'h9, 4, 1); addb(8'h00, 32'h9, 4, 1);
    addb(8'h00, 32'h9, 4, 1); addb(8'h00, 32'h9, 4, 1); addb(8'h01, 32'h9, 4, 1);
    add(1, 8'h01, 0, 1, 1, 32'h1, 4, 1);
    addb(8'h55, 32'h1, 4, 1); addb(8'hAA, 32'h1, 4, 1); addb(8'h00, 32'h1, 4, 1);
    addb(8'h00, 32'h1, 4, 1); addb(8'h00, 32'h1, 4, 1); addb(8'h02, 32'h1, 4, 1);
    add(1, 8'h02, 0, 1, 1, 32'h2, 4, 1);
    addi(1, 32'h2, 4, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].en, tbl[i].data, tbl[i].done, tbl[i].ready);
      $display("vec %0d en=%0d data=%h done=%0d rdy=%0d -> valid=%0d cmd=%h err=%0d drop=%0d",
               i, tbl[i].en, tbl[i].data, tbl[i].done, tbl[i].ready,
               cmd_valid, command_byte, err_cnt, drop_cnt);
      check("vec_valid", 32'(cmd_valid), 32'(tbl[i].ev));
      check("vec_cmd",   command_byte,   tbl[i].ecmd);
      check("vec_err",   32'(err_cnt),   32'(tbl[i].eerr));
      check("vec_drop",  32'(drop_cnt),  32'(tbl[i].edrop));
    end

    // Saturation: 300 bad-checksum frames, model checked every cycle.
    use_model = 1;
    for (int f = 0; f < 300; f++) begin
      cyc(1, 8'h55, 0, 1); cyc(1, 8'hAA, 0, 1); cyc(1, 8'h00, 0, 1); cyc(1, 8'h00, 0, 1);
      cyc(1, 8'h00, 0, 1); cyc(1, 8'h41, 0, 1); cyc(1, 8'h40, 0, 1);
    end
    check("sat_err", 32'(err_cnt), 32'd255);
    $display("saturation: err=%0d drop=%0d cmd=%h", err_cnt, drop_cnt, command_byte);

    // Asynchronous reset after C2: outputs clear before the next clock edge.
    cyc(1, 8'h55, 0, 1); cyc(1, 8'hAA, 0, 1); cyc(1, 8'h01, 0, 1); cyc(1, 8'h02, 0, 1);
    rst_n = 1'b0;
    #1;
    check("arst_cmd",   command_byte,   32'h0);
    check("arst_valid", 32'(cmd_valid), 32'h0);
    check("arst_err",   32'(err_cnt),   32'h0);
    check("arst_drop",  32'(drop_cnt),  32'h0);
    $display("async reset: cmd=%h err=%0d drop=%0d", command_byte, err_cnt, drop_cnt);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Tail bytes C1 C0 CHK are ignored while hunting for HDR0.
    cyc(1, 8'h03, 0, 1); cyc(1, 8'h04, 0, 1); cyc(1, 8'h0A, 0, 1);
    check("tail_cmd", command_byte, 32'h0);
    check("tail_err", 32'(err_cnt), 32'h0);
    cyc(1, 8'h55, 0, 1); cyc(1, 8'hAA, 0, 1); cyc(1, 8'h00, 0, 1); cyc(1, 8'h00, 0, 1);
    cyc(1, 8'h01, 0, 1); cyc(1, 8'h52, 0, 1); cyc(1, 8'h53, 0, 1);
    check("post_rst_valid", 32'(cmd_valid), 32'h1);
    check("post_rst_cmd",   command_byte,   32'h152);
    $display("after reset good frame: valid=%0d cmd=%h", cmd_valid, command_byte);

    // Randomized frames with corruption, gaps, timeouts and packet ends.
    for (int f = 0; f < 400; f++) begin
      kind = int'($urandom_range(0, 9));
      fr[0] = 8'h55; fr[1] = 8'hAA;
      csum = 8'h00;
      for (int k = 2; k < 6; k++) begin
        fr[k] = 8'($urandom_range(0, 255));
        csum = csum + fr[k];
      end
      fr[6] = csum;
      if (kind == 0) fr[6] = csum ^ 8'($urandom_range(1, 255));
      if (kind == 1) fr[1] = 8'($urandom_range(0, 255));
      if (kind == 2) cyc(1, 8'($urandom_range(0, 255)), 0, 1);
      for (int k = 0; k < 7; k++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (kind == 3 && k == 4) gap = TOUT + 4;
        for (int g = 0; g < gap; g++)
          cyc(0, 8'h00, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0));
        cyc(1, fr[k], (k == 6) && ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      end
      $display("rand frame %0d kind=%0d chk=%h -> valid=%0d cmd=%h err=%0d drop=%0d",
               f, kind, fr[6], cmd_valid, command_byte, err_cnt, drop_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_cmd_parser.md
Name: udp_cmd_parser

Overview:
- Sits directly upstream of the command decoder.
- Takes the received UDP payload byte stream from the UDP receive stage and frames it into 32-bit command words.
- Validates header and checksum on each frame.
- Presents each accepted command as a registered `command_byte` with a one-cycle strobe.
- Counts malformed, timed-out and dropped frames for debug.

Parameters:
- `HDR0`, 8'h55, first header byte.
- `HDR1`, 8'hAA, second header byte.
- `TIMEOUT_CYC`, 125000, maximum idle cycles between bytes inside a frame (1 ms at 125 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rec_en`  in  1  payload byte valid, one cycle per byte.
- `rec_data`  in  8  payload byte.
- `rec_pkt_done`  in  1  one-cycle pulse at end of UDP packet.
- `cmd_ready`  in  1  downstream can accept a new command.
- `command_byte`  out  32  last accepted command word.
- `cmd_valid`  out  1  one-cycle pulse when `command_byte` updates.
- `err_cnt`  out  8  header/checksum/abort/timeout errors, saturating.
- `drop_cnt`  out  8  good frames discarded because `cmd_ready` was low, saturating.

Behaviour:
- Reset: asynchronous, active-low, on `rst_n`. Clears `command_byte`=0, `cmd_valid`=0, `err_cnt`=0, `drop_cnt`=0, FSM to S_HDR0, byte index=0, shift register=0, checksum accumulator=0, timeout counter=0. Reset asserted mid-frame discards the partial frame; no strobe is generated.
- Frame format, 7 bytes: `HDR0`, `HDR1`, C3, C2, C1, C0, CHK.
  - Command word = {C3,C2,C1,C0}, big-endian.
  - CHK = (C3+C2+C1+C0) mod 256.
- FSM states, advancing only on cycles with `rec_en`=1:
  - S_HDR0: byte==`HDR0` -> S_HDR1. Any other byte stays in S_HDR0 and counts no error (resync hunt).
  - S_HDR1: byte==`HDR1` -> S_CMD, index=0, checksum=0. Byte==`HDR0` stays in S_HDR1 (repeated sync byte). Any other byte -> S_HDR0 and err_cnt+1.
  - S_CMD: shift byte into the command shift register; add it to the checksum mod 256; index+1. On the 4th byte (index==3) -> S_CHK.
  - S_CHK: byte==checksum -> frame good, then S_HDR0. Otherwise err_cnt+1, then S_HDR0.
- Good frame:
  - `cmd_ready`=1 in the CHK byte cycle: next cycle `command_byte`=shift register and `cmd_valid`=1 for exactly one cycle. Latency is 1 clock after the CHK byte.
  - `cmd_ready`=0: `command_byte` is unchanged, no strobe, drop_cnt+1.
  - `cmd_ready` is sampled only in the CHK byte cycle.
- `rec_pkt_done` handling:
  - Asserted while in S_HDR1, S_CMD or S_CHK (after that cycle's byte is processed): err_cnt+1, FSM -> S_HDR0.
  - Same cycle as a CHK byte that completes a frame: the frame completes normally and no error is counted.
  - In S_HDR0: no effect.
  - Frames never span UDP packets.
- Multiple frames per packet are allowed, back-to-back with no gap bytes. A byte immediately after CHK is evaluated in S_HDR0.
- Timeout:
  - Counter runs while the FSM is not in S_HDR0. It clears on every `rec_en` and on entry to S_HDR0.
  - Reaching `TIMEOUT_CYC`-1 with no byte: err_cnt+1, FSM -> S_HDR0.
  - If `rec_en` arrives on that same cycle, the byte wins and there is no timeout.
- Counters: 8-bit, saturate at 255 and never wrap. Simultaneous error sources in one cycle count once.
- `command_byte` holds its value indefinitely between accepted frames. The downstream decoder may read it combinationally at any time.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Good frame: bytes 55 AA 00 00 01 52 53 with `cmd_ready`=1 -> one cycle after the 53 byte, `command_byte`=32'h00000152 and `cmd_valid` high for one cycle. Downstream sees move_type=2, SDRAM index=1, SD index=5. err_cnt=0.
- Bad checksum: 55 AA 00 00 00 41 40 -> no strobe, `command_byte` keeps its previous value, err_cnt=1. A following good frame 55 AA 00 00 00 41 41 gives `command_byte`=32'h00000041.
- Resync: garbage 12 55 55 AA 00 00 00 42 42 -> one strobe with `command_byte`=32'h00000042, err_cnt=0. Then 55 13 -> err_cnt=1.
- Abort and timeout:
  - 55 AA 00 00 with `rec_pkt_done` on the 2nd 00 -> err_cnt+1, FSM back to S_HDR0.
  - With `TIMEOUT_CYC`=16, 55 AA 00 then 20 idle cycles -> err_cnt+1. A subsequent good frame is accepted.
- Back-pressure: good frame with `cmd_ready`=0 -> drop_cnt=1, no strobe. Two frames back-to-back in one packet with `cmd_ready`=1 -> two strobes 7 cycles apart, values in order.
- Saturation and reset: 300 bad-checksum frames -> err_cnt=255. Assert `rst_n`=0 mid-frame (after byte C2) -> all outputs 0 immediately. After release, the tail bytes are ignored until the next `HDR0`.
